// File: rtl/vx_cache_req_arb.sv
// Cache request arbiter: grants one valid lane per cycle (round-robin or fixed
// priority) into a small FIFO that feeds a single downstream request port.
module vx_cache_req_arb #(
   parameter int NUM_REQS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 30,
   parameter int TAG_WIDTH  = 8,
   parameter int DATA_SIZE  = DATA_WIDTH / 8,
   parameter int BUF_DEPTH  = 2,
   parameter int RR_EN      = 1,
   localparam int LANE_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   localparam int CNT_BITS  = $clog2(BUF_DEPTH + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NUM_REQS-1:0]               req_valid_i,
   input  logic [NUM_REQS-1:0]               req_rw_i,
   input  logic [NUM_REQS*DATA_SIZE-1:0]     req_byteen_i,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [NUM_REQS*DATA_WIDTH-1:0]    req_data_i,
   input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag_i,
   output logic [NUM_REQS-1:0]               req_ready_o,
   output logic                              out_valid_o,
   output logic                              out_rw_o,
   output logic [DATA_SIZE-1:0]              out_byteen_o,
   output logic [ADDR_WIDTH-1:0]             out_addr_o,
   output logic [DATA_WIDTH-1:0]             out_data_o,
   output logic [TAG_WIDTH+LANE_BITS-1:0]    out_tag_o,
   input  logic                              out_ready_i,
   output logic [CNT_BITS-1:0]               count_o
);
   localparam int PTR_BITS = $clog2(BUF_DEPTH);
   localparam int OTAG_W   = TAG_WIDTH + LANE_BITS;
   localparam int ENT_W    = 1 + DATA_SIZE + ADDR_WIDTH + DATA_WIDTH + OTAG_W;

   logic [LANE_BITS-1:0] last_grant;
   logic [LANE_BITS-1:0] cand;
   logic [LANE_BITS-1:0] grant_idx;
   logic [NUM_REQS-1:0]  grant;
   logic                 found;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic [PTR_BITS-1:0]  wr_ptr;
   logic [PTR_BITS-1:0]  rd_ptr;
   logic [ENT_W-1:0]     ent_p0;
   logic [ENT_W-1:0]     ent_p1;
   logic [ENT_W-1:0]     mem [BUF_DEPTH];

   // Arbitration: scan lanes starting just past the last winner (or from lane 0)
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         if (RR_EN != 0) cand = LANE_BITS'((int'(last_grant) + 1 + k) % NUM_REQS);
         else            cand = LANE_BITS'(k);
         if (!found && req_valid_i[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      if (found) grant[grant_idx] = 1'b1;
   end

   // A full queue blocks input regardless of a same-cycle pop
   assign full        = (count_o == CNT_BITS'(BUF_DEPTH));
   assign req_ready_o = (rst_ni && !full) ? grant : '0;
   assign push        = |req_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   // Stage p0: granted lane packed into a queue entry, lane index above the tag
   assign ent_p0 = {req_rw_i[grant_idx],
                    req_byteen_i[int'(grant_idx)*DATA_SIZE +: DATA_SIZE],
                    req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH],
                    req_data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH],
                    grant_idx,
                    req_tag_i[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH]};

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= ent_p0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_o    <= '0;
         last_grant <= LANE_BITS'(NUM_REQS - 1);
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + PTR_BITS'(1);
            last_grant <= grant_idx;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_BITS'(1);
         case ({push, pop})
            2'b10:   count_o <= count_o + CNT_BITS'(1);
            2'b01:   count_o <= count_o - CNT_BITS'(1);
            default: ;
         endcase
      end
   end

   // Stage p1: queue head drives the downstream port
   assign ent_p1      = mem[rd_ptr];
   assign out_valid_o = (count_o != '0);
   assign {out_rw_o, out_byteen_o, out_addr_o, out_data_o, out_tag_o} = ent_p1;

endmodule
